// File: rtl/vis_pkg.sv
// Shared widths, divider iteration count and FSM state encoding for the
// vis_centroid frame-centroid block.
package vis_pkg;

  localparam int M00_W     = 20;
  localparam int M10_W     = 32;
  localparam int M01_W     = 32;
  localparam int COORD_W   = 11;
  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = $clog2(DIV_ITER);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } vis_state_e;

endpackage

// File: rtl/vis_div_seq.sv
// Sequential restoring divider: one quotient bit per cycle, fixed DIV_ITER
// cycles after start, then a one-cycle done pulse with the floor quotient.
module vis_div_seq
  import vis_pkg::*;
#(
  parameter int DVD_W = M10_W,
  parameter int DVS_W = M00_W,
  parameter int Q_W   = COORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [Q_W-1:0]   quotient,
  output logic             done
);

  logic [DVD_W-1:0]     dvd_r;
  logic [DVS_W-1:0]     dvs_r;
  logic [DVS_W-1:0]     rem_r;
  logic [DIV_CNT_W-1:0] cnt_r;
  logic                 busy_r;
  logic                 done_r;
  logic [DVS_W:0]       trial_s;
  logic                 ge_s;
  logic [DVS_W-1:0]     rem_next_s;

  // Trial subtraction; when it succeeds the remainder is below the divisor,
  // so the low DVS_W bits of the difference are exact.
  always_comb begin
    trial_s = {rem_r, dvd_r[DVD_W-1]};
    ge_s    = (trial_s >= {1'b0, dvs_r});
    if (ge_s) begin
      rem_next_s = trial_s[DVS_W-1:0] - dvs_r;
    end else begin
      rem_next_s = trial_s[DVS_W-1:0];
    end
  end

  // Operand load on start, then shift quotient bits into the dividend register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_r  <= {DVD_W{1'b0}};
      dvs_r  <= {DVS_W{1'b0}};
      rem_r  <= {DVS_W{1'b0}};
      cnt_r  <= {DIV_CNT_W{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      dvd_r  <= dividend;
      dvs_r  <= divisor;
      rem_r  <= {DVS_W{1'b0}};
      cnt_r  <= {DIV_CNT_W{1'b0}};
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      dvd_r <= {dvd_r[DVD_W-2:0], ge_s};
      rem_r <= rem_next_s;
      cnt_r <= cnt_r + {{(DIV_CNT_W-1){1'b0}}, 1'b1};
      if (cnt_r == DIV_CNT_W'(DIV_ITER - 1)) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign quotient = dvd_r[Q_W-1:0];
  assign done     = done_r;

endmodule

// File: rtl/vis_centroid.sv
// Per-frame mask centroid: moment accumulation, snapshot at vsync rise, two
// parallel dividers. Optional macro VIS_CENTROID_MIN_AREA_EN enables MIN_AREA.
module vis_centroid
  import vis_pkg::*;
#(
  parameter int IMG_W    = 1280,
  parameter int IMG_H    = 720,
  parameter int MIN_AREA = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               de,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               mask,
  output logic [COORD_W-1:0] x_center,
  output logic [COORD_W-1:0] y_center,
  output logic               valid,
  output logic               overrun
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W-1:0] X_RST  = COORD_W'(IMG_W / 2);
  localparam logic [COORD_W-1:0] Y_RST  = COORD_W'(IMG_H / 2);

  logic               vsync_r;
  logic [COORD_W-1:0] x_pos_r, y_pos_r;
  logic [M00_W-1:0]   m00_r, snap_m00_r;
  logic [M10_W-1:0]   m10_r, snap_m10_r;
  logic [M01_W-1:0]   m01_r, snap_m01_r;
  vis_state_e         state_r, next_state_s;
  logic               start_r;
  logic               frame_end_s, area_ok_s, div_start_s, overrun_set_s;
  logic [COORD_W-1:0] x_quot_s, y_quot_s;
  logic               x_done_s, y_done_s;
  logic [COORD_W-1:0] x_center_r, y_center_r;
  logic               valid_r, overrun_r;

  assign frame_end_s = vsync & ~vsync_r;

`ifdef VIS_CENTROID_MIN_AREA_EN
  assign area_ok_s = (m00_r >= M00_W'(MIN_AREA));
`else
  assign area_ok_s = (m00_r != {M00_W{1'b0}});
`endif

  // vsync history and raster position counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_r <= 1'b0;
      x_pos_r <= {COORD_W{1'b0}};
      y_pos_r <= {COORD_W{1'b0}};
    end else begin
      vsync_r <= vsync;
      if (vsync) begin
        x_pos_r <= {COORD_W{1'b0}};
        y_pos_r <= {COORD_W{1'b0}};
      end else if (de) begin
        if (x_pos_r == X_LAST) begin
          x_pos_r <= {COORD_W{1'b0}};
          y_pos_r <= (y_pos_r == Y_LAST) ? {COORD_W{1'b0}} : y_pos_r + {{(COORD_W-1){1'b0}}, 1'b1};
        end else begin
          x_pos_r <= x_pos_r + {{(COORD_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Moment accumulators; frame end snapshots them (only when idle) and restarts at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      m00_r      <= {M00_W{1'b0}};
      m10_r      <= {M10_W{1'b0}};
      m01_r      <= {M01_W{1'b0}};
      snap_m00_r <= {M00_W{1'b0}};
      snap_m10_r <= {M10_W{1'b0}};
      snap_m01_r <= {M01_W{1'b0}};
    end else if (frame_end_s) begin
      if (state_r == ST_IDLE) begin
        snap_m00_r <= m00_r;
        snap_m10_r <= m10_r;
        snap_m01_r <= m01_r;
      end
      m00_r <= {M00_W{1'b0}};
      m10_r <= {M10_W{1'b0}};
      m01_r <= {M01_W{1'b0}};
    end else if (de && mask) begin
      m00_r <= m00_r + {{(M00_W-1){1'b0}}, 1'b1};
      m10_r <= m10_r + M10_W'(x_pos_r);
      m01_r <= m01_r + M01_W'(y_pos_r);
    end
  end

  // State register and registered divider start (dividers load the snapshot).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      start_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      start_r <= div_start_s;
    end
  end

  // Next-state logic; a frame end while busy only raises overrun.
  always_comb begin
    next_state_s  = state_r;
    div_start_s   = 1'b0;
    overrun_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (frame_end_s && area_ok_s) begin
          next_state_s = ST_DIV;
          div_start_s  = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_DIV: begin
        overrun_set_s = frame_end_s;
        if (x_done_s && y_done_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_DIV;
        end
      end
      ST_DONE: begin
        overrun_set_s = frame_end_s;
        next_state_s  = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  vis_div_seq #(.DVD_W(M10_W), .DVS_W(M00_W), .Q_W(COORD_W)) u_div_x (
    .clk      (clk),
    .rst      (rst),
    .start    (start_r),
    .dividend (snap_m10_r),
    .divisor  (snap_m00_r),
    .quotient (x_quot_s),
    .done     (x_done_s)
  );

  vis_div_seq #(.DVD_W(M01_W), .DVS_W(M00_W), .Q_W(COORD_W)) u_div_y (
    .clk      (clk),
    .rst      (rst),
    .start    (start_r),
    .dividend (snap_m01_r),
    .divisor  (snap_m00_r),
    .quotient (y_quot_s),
    .done     (y_done_s)
  );

  // Result registers: loaded as the FSM enters DONE, so valid is high exactly in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_center_r <= X_RST;
      y_center_r <= Y_RST;
      valid_r    <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      if ((state_r == ST_DIV) && x_done_s && y_done_s) begin
        x_center_r <= x_quot_s;
        y_center_r <= y_quot_s;
        valid_r    <= 1'b1;
      end else begin
        valid_r    <= 1'b0;
      end
      if (overrun_set_s) begin
        overrun_r <= 1'b1;
      end
    end
  end

  assign x_center = x_center_r;
  assign y_center = y_center_r;
  assign valid    = valid_r;
  assign overrun  = overrun_r;

endmodule

// File: tb/tb_vis_centroid.sv
// Randomised and directed bench for vis_centroid on a reduced 128x64 raster;
// expected centroids come from pixel sums kept while driving each frame.
module tb_vis_centroid;

  localparam int W  = 128;
  localparam int H  = 64;
  localparam int MA = 64;

  logic        clk = 1'b0;
  logic        rst, de, hsync, vsync, mask;
  logic [10:0] x_center, y_center;
  logic        valid, overrun;

  int     n_total = 0;
  int     n_bad   = 0;
  int     exp_x, exp_y;
  bit     exp_ovr;
  int     cnt;
  longint sx, sy;

  always #5 clk = ~clk;

  vis_centroid #(.IMG_W(W), .IMG_H(H), .MIN_AREA(MA)) dut (
    .clk      (clk),
    .rst      (rst),
    .de       (de),
    .hsync    (hsync),
    .vsync    (vsync),
    .mask     (mask),
    .x_center (x_center),
    .y_center (y_center),
    .valid    (valid),
    .overrun  (overrun)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: empty, 1: rectangle, 2: random density dens%, 3: all ones
  task automatic drive_frame(input int lines, input int mode, input int x0, input int x1,
                             input int y0, input int y1, input int dens);
    cnt = 0; sx = 0; sy = 0;
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < W; x++) begin
        logic m;
        case (mode)
          0:       m = 1'b0;
          1:       m = (x >= x0 && x <= x1 && y >= y0 && y <= y1);
          2:       m = ($urandom_range(99) < dens);
          default: m = 1'b1;
        endcase
        de = 1'b1; mask = m;
        if (m) begin cnt++; sx += x; sy += y; end
        tick();
      end
      de = 1'b0; mask = 1'($urandom_range(1)); hsync = 1'b1;
      tick(); tick();
      hsync = 1'b0; mask = 1'b0;
    end
  endtask

  task automatic end_frame(input string nm, input bit ovr_pulse);
    bit acc;
    int first_k = 0;
    int nvalid  = 0;
`ifdef VIS_CENTROID_MIN_AREA_EN
    acc = (cnt >= MA);
`else
    acc = (cnt != 0);
`endif
    vsync = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid === 1'b1) begin
        nvalid++;
        if (first_k == 0) first_k = k;
      end
      if (k == 2) vsync = 1'b0;
      if (ovr_pulse && k == 4) vsync = 1'b1;
      if (ovr_pulse && k == 6) vsync = 1'b0;
    end
    if (acc) begin
      exp_x = int'(sx / cnt);
      exp_y = int'(sy / cnt);
      check_eq({nm, "_latency"}, first_k, 34);
      check_eq({nm, "_npulse"}, nvalid, 1);
      if (ovr_pulse) exp_ovr = 1'b1;
    end else begin
      check_eq({nm, "_npulse"}, nvalid, 0);
    end
    check_eq({nm, "_x"}, x_center, exp_x);
    check_eq({nm, "_y"}, y_center, exp_y);
    check_eq({nm, "_overrun"}, overrun, exp_ovr);
  endtask

  initial begin
    int nv;
    rst = 1'b1; de = 1'b0; hsync = 1'b0; vsync = 1'b0; mask = 1'b0;
    exp_x = W / 2; exp_y = H / 2; exp_ovr = 1'b0;
    repeat (4) tick();
    check_eq("rst_x", x_center, W / 2);
    check_eq("rst_y", y_center, H / 2);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_overrun", overrun, 0);
    rst = 1'b0;
    repeat (3) tick();

    drive_frame(51, 1, 100, 100, 50, 50, 0);
    end_frame("single", 1'b0);
    drive_frame(4, 0, 0, 0, 0, 0, 0);
    end_frame("empty", 1'b0);
    drive_frame(22, 1, 10, 11, 20, 21, 0);
    end_frame("floor2x2", 1'b0);
    drive_frame(14, 1, 30, 36, 5, 13, 0);
    end_frame("blob63", 1'b0);

    for (int i = 0; i < 5; i++) begin
      drive_frame(int'($urandom_range(12, 1)), 2, 0, 0, 0, 0, int'($urandom_range(60)));
      end_frame("rand", 1'b0);
    end

    drive_frame(9, 1, 40, 47, 2, 8, 0);
    end_frame("ovr_first", 1'b1);
    drive_frame(6, 2, 0, 0, 0, 0, 30);
    end_frame("ovr_sticky", 1'b0);

    drive_frame(10, 1, 5, 60, 1, 9, 0);
    vsync = 1'b1;
    @(posedge clk);
    #1 vsync = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    nv = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (valid === 1'b1) nv++;
    end
    exp_x = W / 2; exp_y = H / 2; exp_ovr = 1'b0;
    check_eq("div_rst_npulse", nv, 0);
    check_eq("div_rst_x", x_center, exp_x);
    check_eq("div_rst_y", y_center, exp_y);
    check_eq("div_rst_overrun", overrun, 0);

    drive_frame(H, 3, 0, 0, 0, 0, 0);
    end_frame("full", 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
